phase_offset_generator: RTL

Produces `generated_o`, a copy of the asynchronous reference clock `reference_i` delayed by a programmable number of `fpga_clk_i` cycles. It is the transmitting counterpart of the delay-line phase detector. The phase detector measures a reference/generated phase offset in fpga clock cycles; this block creates a known offset. The block supplies closed-loop stimulus for the ADPLL and lets the detector be calibrated in hardware.

---
 rtl/phase_offset_generator.sv | 120 ++++++++++++
 1 files changed

// File: rtl/phase_offset_generator.sv
// phase_offset_generator: replays reference_i edges on generated_o
// after a programmable delay, counted in fpga_clk_i cycles.
//
// Ports:
//   fpga_clk_i      - block clock
//   reset_i         - synchronous active-high reset
//   reference_i     - asynchronous reference clock
//   offset_cycles_i - delay per edge, sampled when the edge is queued
//   generated_o     - delayed replica of the reference
//   pending_o       - number of queued edges
//   overflow_o      - sticky, set when an edge is dropped
module phase_offset_generator #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                       fpga_clk_i,
  input  logic                       reset_i,
  input  logic                       reference_i,
  input  logic [WIDTH-1:0]           offset_cycles_i,
  output logic                       generated_o,
  output logic [$clog2(DEPTH+1)-1:0] pending_o,
  output logic                       overflow_o
);

  localparam int TW = WIDTH + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync3;
  logic [TW-1:0] r_ts;
  logic          r_lvl [DEPTH];
  logic [TW-1:0] r_due [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          r_gen;
  logic          r_ovf;

  logic          w_edge;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [TW-1:0] w_late;
  logic [TW-1:0] w_due;

  function automatic logic [PW-1:0] f_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_edge  = r_sync2 ^ r_sync3;
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));

  // Head is due when ts has reached or passed its stamp
  // (MSB of the modular difference clear).
  assign w_late  = r_ts - r_due[r_rd];
  assign w_pop   = !w_empty && !w_late[TW-1];

  // A full FIFO still accepts the edge if a slot frees
  // up in the same cycle.
  assign w_push  = w_edge && (!w_full || w_pop);

  // Stamp against the count of the following cycle so the
  // entry pops exactly offset cycles after the push edge,
  // giving k + 3 + offset from synchronizer capture.
  assign w_due   = r_ts + TW'(offset_cycles_i) + TW'(1);

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_ts    <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_gen   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_sync1 <= reference_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_ts    <= r_ts + TW'(1);
      if (w_push) begin
        r_wr <= f_inc(r_wr);
      end
      if (w_pop) begin
        r_rd  <= f_inc(r_rd);
        r_gen <= r_lvl[r_rd];
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_edge && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Entry storage needs no reset: pointers and count
  // define which slots are valid.
  always_ff @(posedge fpga_clk_i) begin
    if (w_push) begin
      r_lvl[r_wr] <= r_sync2;
      r_due[r_wr] <= w_due;
    end
  end

  assign generated_o = r_gen;
  assign pending_o   = r_cnt;
  assign overflow_o  = r_ovf;

endmodule
